// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous SRAM.
// Data side wins by default; a fetch request that has been denied for
// STARVE_LIMIT consecutive cycles wins over data for one cycle.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    // fetch side (read-only)
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,
    // load/store side
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    // shared SRAM
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stallreq
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DRD  = 2'd2,
        OWN_DWR  = 2'd3
    } owner_e;

    localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

    owner_e      owner_q, owner_d;
    logic [1:0]  starve_q, starve_d;
    logic [31:0] inst_hold_q, inst_hold_d;
    logic [31:0] data_hold_q, data_hold_d;
    logic        inst_pri;

    // Grant decision and SRAM request mux; everything is held low in reset.
    always_comb begin
        inst_pri  = inst_req && (starve_q >= LIMIT);
        inst_gnt  = !rst && inst_req && (inst_pri || !data_req);
        data_gnt  = !rst && data_req && !inst_pri;
        mem_en    = inst_gnt || data_gnt;
        mem_wen   = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (inst_gnt) begin
            mem_addr = inst_addr;
        end else if (data_gnt) begin
            mem_addr  = data_addr;
            mem_wen   = data_wen;
            mem_wdata = data_wdata;
        end
        stallreq = !rst && ((inst_req && !inst_gnt) || (data_req && !data_gnt));
    end

    // Read return path: live SRAM data on the rvalid cycle, held copy otherwise.
    always_comb begin
        inst_rvalid = (owner_q == OWN_INST);
        data_rvalid = (owner_q == OWN_DRD);
        inst_rdata  = inst_rvalid ? mem_rdata : inst_hold_q;
        data_rdata  = data_rvalid ? mem_rdata : data_hold_q;
        inst_hold_d = inst_rdata;
        data_hold_d = data_rdata;
    end

    // Next owner and starve count from this cycle's grant.
    always_comb begin
        owner_d = OWN_NONE;
        if (inst_gnt)      owner_d = OWN_INST;
        else if (data_gnt) owner_d = (data_wen == 4'd0) ? OWN_DRD : OWN_DWR;
        starve_d = 2'd0;
        if (inst_req && !inst_gnt)
            starve_d = (starve_q == 2'd3) ? 2'd3 : starve_q + 2'd1;
    end

    // State registers; reset drops any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            starve_q    <= 2'd0;
            inst_hold_q <= 32'd0;
            data_hold_q <= 32'd0;
        end else begin
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            inst_hold_q <= inst_hold_d;
            data_hold_q <= data_hold_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the driver predicts each cycle's outputs
// from a behavioural model and queues them; the monitor checks at negedge.
module tb_mem_arbiter;

    localparam int LIM = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req;
    logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
    logic [3:0]  data_wen;
    logic        inst_gnt, inst_rvalid, data_gnt, data_rvalid;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_en, stallreq;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stallreq(stallreq)
    );

    typedef struct {
        logic        ig, dg, en, iv, dv, st;
        logic [3:0]  wen;
        logic [31:0] addr, wd, ird, drd;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // reference model: count of consecutive denied fetch cycles, which
    // requester has a read returning next cycle, last data seen per side
    int          denied;
    int          pending;   // 0 none, 1 fetch read, 2 data read
    logic [31:0] ihold, dhold;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // one bus cycle: apply inputs, predict the outputs of this cycle
    task automatic cyc(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [3:0] dw, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [31:0] mrd);
        exp_t e;
        bit ig, dg;
        @(posedge clk);
        #1;
        rst = r; inst_req = ir; inst_addr = ia; data_req = dr; data_wen = dw;
        data_addr = da; data_wdata = dwd; mem_rdata = mrd;
        if (r) begin
            e = '{ig:0, dg:0, en:0, iv:0, dv:0, st:0, wen:0, addr:0, wd:0, ird:0, drd:0};
            denied = 0; pending = 0; ihold = 0; dhold = 0;
        end else begin
            ig = ir && (denied >= LIM || !dr);
            dg = dr && !ig;
            e.ig   = ig;
            e.dg   = dg;
            e.en   = ig || dg;
            e.addr = ig ? ia : (dg ? da : 32'd0);
            e.wen  = dg ? dw : 4'd0;
            e.wd   = dg ? dwd : 32'd0;
            e.st   = (ir && !ig) || (dr && !dg);
            e.iv   = (pending == 1);
            e.dv   = (pending == 2);
            e.ird  = e.iv ? mrd : ihold;
            e.drd  = e.dv ? mrd : dhold;
            ihold  = e.ird;
            dhold  = e.drd;
            pending = ig ? 1 : ((dg && dw == 4'd0) ? 2 : 0);
            denied  = (ir && !ig) ? denied + 1 : 0;
        end
        exp_q.push_back(e);
    endtask

    // monitor: compare whatever the driver predicted for this cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("inst_gnt",    32'(inst_gnt),    32'(e.ig));
            chk("data_gnt",    32'(data_gnt),    32'(e.dg));
            chk("mem_en",      32'(mem_en),      32'(e.en));
            chk("mem_addr",    mem_addr,         e.addr);
            chk("mem_wen",     32'(mem_wen),     32'(e.wen));
            chk("mem_wdata",   mem_wdata,        e.wd);
            chk("stallreq",    32'(stallreq),    32'(e.st));
            chk("inst_rvalid", 32'(inst_rvalid), 32'(e.iv));
            chk("data_rvalid", 32'(data_rvalid), 32'(e.dv));
            chk("inst_rdata",  inst_rdata,       e.ird);
            chk("data_rdata",  data_rdata,       e.drd);
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1; inst_req = 0; data_req = 0; inst_addr = 0; data_addr = 0;
        data_wen = 0; data_wdata = 0; mem_rdata = 0;
        denied = 0; pending = 0; ihold = 0; dhold = 0;

        // reset state, with live requests that must be ignored
        cyc(1, 1, 32'h1111_0000, 1, 4'h0, 32'h2222_0000, 32'h0, 32'hDEAD_BEEF);
        cyc(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0);

        // lone fetch, then its read data next cycle
        cyc(0, 1, 32'hBFC0_0000, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        cyc(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h3C01_0001);
        // both request: data load wins, fetch data holds
        cyc(0, 1, 32'hBFC0_0004, 1, 4'h0, 32'h8000_0010, 32'h0, 32'h0);
        cyc(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h1234_5678);
        // both held high: fetch wins on the fourth cycle, data on the fifth
        for (int i = 0; i < 6; i++)
            cyc(0, 1, 32'hBFC0_0100 + 32'(i), 1, 4'h0, 32'h8000_0100 + 32'(i), 32'h0, $urandom);
        // partial store: no data_rvalid after it
        cyc(0, 0, 32'h0, 1, 4'b0011, 32'h8000_0020, 32'h0000_BEEF, 32'h0);
        cyc(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'hAAAA_5555);
        // reset right after a fetch grant discards the read, then regrant
        cyc(0, 1, 32'hBFC0_0200, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        cyc(1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h5555_AAAA);
        cyc(0, 1, 32'hBFC0_0204, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        cyc(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0BAD_F00D);

        // randomized traffic, biased toward contention, with sporadic reset
        for (int i = 0; i < 800; i++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            cyc($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, $urandom,
                $urandom_range(0, 3) != 0, w, $urandom, $urandom, $urandom);
        end
        cyc(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain queue left %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, the number of consecutive cycles a pending instruction request may be denied before it gets priority (legal range 1-3).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports inst_req in 1, inst_addr in 32, inst_gnt out 1, inst_rvalid out 1, inst_rdata out 32, forming the fetch-side requester (read-only).
REQ-005 SHALL have ports data_req in 1, data_wen in 4, data_addr in 32, data_wdata in 32, data_gnt out 1, data_rvalid out 1, data_rdata out 32, forming the load/store-side requester.
REQ-006 SHALL have ports mem_en out 1, mem_wen out 4, mem_addr out 32, mem_wdata out 32, mem_rdata in 32, forming the shared single-port synchronous SRAM (read data valid the cycle after mem_en with mem_wen==0).
REQ-007 SHALL have port stallreq  out  1  pipeline stall request to the stall controller.

Function
REQ-008 SHALL grant at most one requester per cycle; inst_gnt and data_gnt are combinational from the current requests and the state.
REQ-009 SHALL give data priority by default: data_req=1 -> data_gnt=1, inst_gnt=0.
REQ-010 SHALL keep a 2-bit starve counter, incremented each cycle inst_req=1 and inst_gnt=0 (saturating), and cleared when inst_gnt=1 or inst_req=0.
REQ-011 SHALL, when starve counter >= STARVE_LIMIT and inst_req=1, grant inst over data that cycle; data_gnt=0.
REQ-012 SHALL drive mem_en=1 and mem_addr, mem_wen and mem_wdata from the granted requester in the grant cycle; with no grant, mem_en=0, mem_wen=0, and mem_addr and mem_wdata are 0.
REQ-013 SHALL force mem_wen=0 and mem_wdata=0 for inst grants.
REQ-014 SHALL register an owner state {NONE, INST, DATA_RD, DATA_WR} on each edge from the current grant (NONE when no grant).
REQ-015 SHALL, in the cycle after a grant with owner INST, assert inst_rvalid=1 for exactly one cycle; with owner DATA_RD, assert data_rvalid=1 for exactly one cycle; DATA_WR produces no rvalid.
REQ-016 SHALL, when rvalid is asserted, present mem_rdata combinationally on the matching rdata, and capture it into a hold register at the same edge.
REQ-017 SHALL present the hold-register value on inst_rdata and data_rdata in every other cycle, so each output stays stable until that requester's next rvalid.
REQ-018 SHALL drive stallreq = (inst_req & ~inst_gnt) | (data_req & ~data_gnt), combinationally.
REQ-019 SHALL accept back-to-back grants, one per cycle, with throughput of one access per cycle and read latency of exactly 1 cycle.
REQ-020 SHALL let a requester change its address while not granted; only the signals in the grant cycle are used.
REQ-021 SHALL treat simultaneous requests with the counter below the limit as a data grant, and the counter increments.

Reset
REQ-022 SHALL, while rst=1, clear owner to NONE, the starve counter to 0, and both rdata hold registers to 0.
REQ-023 SHALL, while rst=1, drive inst_gnt, data_gnt, inst_rvalid, data_rvalid, mem_en, mem_wen, mem_addr, mem_wdata and stallreq to 0.
REQ-024 SHALL discard a read in flight when reset is asserted, with no rvalid after deassertion.
REQ-025 SHALL accept requests in the first edge after rst deasserts.

Verification
REQ-026 Only inst_req=1, addr 0xBFC00000, mem_rdata next cycle 0x3C010001 -> inst_gnt same cycle; inst_rvalid=1 and inst_rdata=0x3C010001 next cycle; stallreq=0.
REQ-027 Both requests in the same cycle, data a load from 0x80000010 -> data_gnt=1, mem_addr=0x80000010, stallreq=1; data_rvalid next cycle, while inst_rdata holds its old value.
REQ-028 data_req held high and inst_req held high, STARVE_LIMIT=3 -> inst granted on cycle 4, data stalled that cycle, then data granted again on cycle 5.
REQ-029 Store with data_wen=4'b0011, wdata 0x0000BEEF, addr 0x80000020 -> mem_wen=4'b0011, mem_wdata=0x0000BEEF; no data_rvalid the following cycle.
REQ-030 Assert rst in the cycle after an inst grant -> inst_rvalid=0, inst_rdata=0, and all outputs 0 immediately; a normal grant on the first edge after release.
